// File: rtl/stream_pkg.sv
// Shared types and helpers for the stream routing blocks.
package stream_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    PKT  = 1'b1
  } state_t;

  localparam string OUT_BUF_TRUE  = "TRUE";
  localparam string OUT_BUF_FALSE = "FALSE";

  function automatic int clogb2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < v) r = i + 1;
    return r;
  endfunction

endpackage

// File: rtl/stream_skid_buffer.sv
// Two-entry valid/ready buffer: full throughput, in_ready comes straight from a flop.
module stream_skid_buffer #(
  parameter int WIDTH = 33
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready
);

  logic [WIDTH-1:0] skid_data;
  logic             skid_valid;

  assign in_ready = ~skid_valid;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      out_data   <= '0;
      out_valid  <= 1'b0;
      skid_data  <= '0;
      skid_valid <= 1'b0;
    end else if (!out_valid || out_ready) begin
      // Main register frees up: refill from skid first to keep beat order.
      if (skid_valid) begin
        out_data   <= skid_data;
        out_valid  <= 1'b1;
        skid_valid <= 1'b0;
      end else begin
        out_valid <= in_valid;
        if (in_valid) out_data <= in_data;
      end
    end else if (in_valid && !skid_valid) begin
      skid_data  <= in_data;
      skid_valid <= 1'b1;
    end
  end

endmodule

// File: rtl/stream_demux.sv
// 1-to-2 packet demultiplexer: the select is locked on a packet's first beat until its last beat.
module stream_demux
  import stream_pkg::*;
#(
  parameter int    DATA_WIDTH = 32,
  parameter string OUT_BUF    = "FALSE",
  parameter int    CNT_WIDTH  = 16
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  in_select,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_last,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] out_data_0,
  output logic                  out_last_0,
  output logic                  out_valid_0,
  input  logic                  out_ready_0,
  output logic [DATA_WIDTH-1:0] out_data_1,
  output logic                  out_last_1,
  output logic                  out_valid_1,
  input  logic                  out_ready_1,
  output logic                  active_sel,
  output logic                  in_packet,
  output logic [CNT_WIDTH-1:0]  pkt_count_0,
  output logic [CNT_WIDTH-1:0]  pkt_count_1
);

  state_t     state;
  logic       eff_sel;
  logic       in_xfer;
  logic [1:0] route_valid;
  logic [1:0] route_ready;

  assign eff_sel     = (state == PKT) ? active_sel : in_select;
  assign in_packet   = (state == PKT);
  assign route_valid = {in_valid & eff_sel, in_valid & ~eff_sel};
  assign in_ready    = reset_n & route_ready[eff_sel];
  assign in_xfer     = in_valid & in_ready;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      active_sel  <= 1'b0;
      pkt_count_0 <= '0;
      pkt_count_1 <= '0;
    end else if (in_xfer) begin
      active_sel <= eff_sel;
      if (in_last) begin
        state <= IDLE;
        if (eff_sel) pkt_count_1 <= pkt_count_1 + CNT_WIDTH'(1);
        else         pkt_count_0 <= pkt_count_0 + CNT_WIDTH'(1);
      end else begin
        state <= PKT;
      end
    end
  end

  if (OUT_BUF == OUT_BUF_TRUE) begin : g_buf
    logic [1:0][DATA_WIDTH:0] buf_data;
    logic [1:0]               buf_valid;
    logic [1:0]               buf_ready;

    assign buf_ready = {out_ready_1, out_ready_0};

    // Each output drains on its own, so a switch never waits on the other side.
    for (genvar x = 0; x < 2; x++) begin : g_out
      stream_skid_buffer #(.WIDTH(DATA_WIDTH + 1)) u_skid (
        .clock     (clock),
        .reset_n   (reset_n),
        .in_data   ({in_last, in_data}),
        .in_valid  (route_valid[x]),
        .in_ready  (route_ready[x]),
        .out_data  (buf_data[x]),
        .out_valid (buf_valid[x]),
        .out_ready (buf_ready[x])
      );
    end

    assign {out_last_0, out_data_0} = buf_data[0];
    assign {out_last_1, out_data_1} = buf_data[1];
    assign out_valid_0 = buf_valid[0];
    assign out_valid_1 = buf_valid[1];
  end else begin : g_pass
    assign route_ready = {out_ready_1, out_ready_0};
    assign out_valid_0 = reset_n & route_valid[0];
    assign out_valid_1 = reset_n & route_valid[1];
    assign out_data_0  = reset_n ? in_data : '0;
    assign out_data_1  = reset_n ? in_data : '0;
    assign out_last_0  = reset_n & in_last;
    assign out_last_1  = reset_n & in_last;
  end

endmodule
